// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the LSB memory-request channel and the RAM/IO bus controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE
    } state_t;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;
    localparam logic [1:0] IO_ADDR_HI = 2'b11;

    // Size code 3 is illegal and behaves as a word access.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            MEM_SIZE_B: return 3'd1;
            MEM_SIZE_H: return 3'd2;
            default:    return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_load_ext.sv
// Load result extension: sign- or zero-extends byte/half loads, passes words through.
module mem_ctrl_load_ext
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (size)
            MEM_SIZE_B: ext = {{24{raw[7] & ~is_unsigned}}, raw[7:0]};
            MEM_SIZE_H: ext = {{16{raw[15] & ~is_unsigned}}, raw[15:0]};
            default:    ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Memory request responder: takes one LSB load/store at a time and serialises it
// byte by byte onto the RAM port, returning extended load data or a store acknowledge.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = IO_ADDR_HI
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              clear_in,
    input  logic              req_valid_in,
    output logic              req_ready_out,
    input  logic              req_wr_in,
    input  logic [1:0]        req_size_in,
    input  logic              req_unsigned_in,
    input  logic [ADDR_W-1:0] req_addr_in,
    input  logic [31:0]       req_wdata_in,
    output logic              resp_valid_out,
    output logic [31:0]       resp_data_out,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    state_t            state, state_nx;
    logic              uns_r;
    logic [1:0]        size_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r, data_r, raw_nx, ext_data, resp_data_r;
    logic [2:0]        ai_r, nbytes, a_idx;
    logic [1:0]        bi_r;
    logic              pend_r, resync_r, resp_valid_r;
    logic              accept, rd_done, wr_done, io_stall;

    assign nbytes         = size_bytes(size_r);
    assign io_stall       = (state == ST_WRITE) && (addr_r[17:16] == IO_HI) && io_buffer_full;
    // After a freeze the RAM has been sampling a stale address, so re-issue the byte still owed.
    assign a_idx          = resync_r ? {1'b0, bi_r} : ai_r;
    assign mem_a          = addr_r + {{(ADDR_W-3){1'b0}}, a_idx};
    assign mem_dout       = wdata_r[{ai_r[1:0], 3'b000} +: 8];
    assign resp_valid_out = resp_valid_r & rdy_in;
    assign resp_data_out  = resp_data_r;

    always_comb begin
        raw_nx = data_r;
        raw_nx[{bi_r, 3'b000} +: 8] = mem_din;
    end

    mem_ctrl_load_ext u_load_ext (
        .size        (size_r),
        .is_unsigned (uns_r),
        .raw         (raw_nx),
        .ext         (ext_data)
    );

    always_comb begin
        state_nx      = state;
        req_ready_out = (state == ST_IDLE) && rdy_in && !clear_in;
        accept        = req_valid_in && req_ready_out;
        mem_wr        = (state == ST_WRITE) && rdy_in && !io_stall;
        rd_done       = (state == ST_READ) && !clear_in && !resync_r && pend_r &&
                        ({1'b0, bi_r} == nbytes - 3'd1);
        wr_done       = (state == ST_WRITE) && !io_stall && (ai_r == nbytes - 3'd1);
        case (state)
            ST_IDLE:  if (accept) state_nx = req_wr_in ? ST_WRITE : ST_READ;
            ST_READ:  if (clear_in || rd_done) state_nx = ST_IDLE;
            ST_WRITE: if (wr_done) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= ST_IDLE;
        else if (rdy_in) state <= state_nx;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            uns_r        <= 1'b0;
            size_r       <= 2'd0;
            addr_r       <= '0;
            wdata_r      <= '0;
            data_r       <= '0;
            ai_r         <= 3'd0;
            bi_r         <= 2'd0;
            pend_r       <= 1'b0;
            resync_r     <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_data_r  <= '0;
        end else if (rdy_in) begin
            resp_valid_r <= 1'b0;
            if (accept) begin
                uns_r    <= req_unsigned_in;
                size_r   <= req_size_in;
                addr_r   <= req_addr_in;
                wdata_r  <= req_wdata_in;
                data_r   <= '0;
                ai_r     <= 3'd0;
                bi_r     <= 2'd0;
                pend_r   <= 1'b0;
                resync_r <= 1'b0;
            end else if (state == ST_READ) begin
                if (clear_in) begin
                    pend_r   <= 1'b0;
                    resync_r <= 1'b0;
                end else if (resync_r) begin
                    resync_r <= 1'b0;
                    pend_r   <= 1'b1;
                    ai_r     <= {1'b0, bi_r} + 3'd1;
                end else begin
                    // pend_r: the byte addressed last cycle is on mem_din now.
                    if (pend_r) begin
                        data_r <= raw_nx;
                        bi_r   <= bi_r + 2'd1;
                    end
                    if (rd_done) begin
                        resp_valid_r <= 1'b1;
                        resp_data_r  <= ext_data;
                        pend_r       <= 1'b0;
                    end else if (ai_r < nbytes) begin
                        ai_r   <= ai_r + 3'd1;
                        pend_r <= 1'b1;
                    end else begin
                        pend_r <= 1'b0;
                    end
                end
            end else if (state == ST_WRITE && !io_stall) begin
                if (wr_done) begin
                    resp_valid_r <= 1'b1;
                    resp_data_r  <= '0;
                end else begin
                    ai_r <= ai_r + 3'd1;
                end
            end
        end else if (state == ST_READ) begin
            resync_r <= 1'b1;
        end
    end

endmodule
